// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`default_nettype none

package inst_fetch_pkg;

  typedef logic [31:0] InstAddr;
  typedef logic [31:0] Inst;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } FetchState;

  localparam InstAddr INST_BYTES = 32'd4;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: PC redirect input, instruction memory port and decode handshake.
`default_nettype none

interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic    redirect;
  InstAddr redirect_pc;
  InstAddr mem_addr;
  logic    mem_read;
  logic    mem_ready;
  Inst     mem_data;
  logic    valid;
  Inst     inst;
  InstAddr pc;
  logic    misaligned;
  logic    ready;

  modport master (
    input  redirect, redirect_pc, mem_ready, mem_data, ready,
    output mem_addr, mem_read, valid, inst, pc, misaligned
  );

  modport slave (
    output redirect, redirect_pc, mem_ready, mem_data, ready,
    input  mem_addr, mem_read, valid, inst, pc, misaligned
  );

endinterface

`default_nettype wire

// File: rtl/inst_fetch_half_adder.sv
// Width-parameterised adder with the carry-out discarded, so sums wrap modulo 2^WIDTH.
`default_nettype none

module inst_fetch_half_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, one outstanding memory read, single-entry decode buffer.
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter InstAddr RESET_PC = 32'h0000_0000
) (
  input  logic         i_clock,
  input  logic         i_reset,
  inst_fetch_if.master bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_DROP = DROP;

  logic [1:0] state;
  logic [1:0] state_next;
  InstAddr    pc;
  InstAddr    pc_inc;
  InstAddr    drop_addr;
  logic       buf_valid;
  Inst        buf_inst;
  InstAddr    buf_pc;
  logic       buf_mis;
  logic       fill;
  logic       take;
  logic       can_issue;

  inst_fetch_half_adder #(
    .WIDTH($bits(InstAddr))
  ) u_pc_inc (
    .a   (pc),
    .b   (INST_BYTES),
    .sum (pc_inc)
  );

  assign bus.mem_read   = (state == S_REQ) || (state == S_DROP);
  assign bus.mem_addr   = (state == S_DROP) ? drop_addr : pc;
  assign bus.valid      = buf_valid;
  assign bus.inst       = buf_inst;
  assign bus.pc         = buf_pc;
  assign bus.misaligned = buf_mis;

  assign fill      = (state == S_REQ) && bus.mem_ready && !bus.redirect;
  assign take      = buf_valid && bus.ready;
  // Only issue when the buffer will be empty by the time the ack can land.
  assign can_issue = !bus.redirect && (!buf_valid || bus.ready);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (can_issue) state_next = S_REQ;
      S_REQ: begin
        if (bus.mem_ready)     state_next = S_IDLE;
        else if (bus.redirect) state_next = S_DROP;
      end
      S_DROP: if (bus.mem_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state <= state_next;
      if (bus.redirect)  pc <= bus.redirect_pc;
      else if (fill)     pc <= pc_inc;
      // The squashed read must keep presenting its original address until acked.
      if ((state == S_REQ) && bus.redirect && !bus.mem_ready) drop_addr <= pc;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      buf_valid <= 1'b0;
      buf_inst  <= '0;
      buf_pc    <= '0;
      buf_mis   <= 1'b0;
    end else begin
      if (bus.redirect)  buf_valid <= 1'b0;
      else if (fill)     buf_valid <= 1'b1;
      else if (take)     buf_valid <= 1'b0;
      if (fill) begin
        buf_inst <= bus.mem_data;
        buf_pc   <= pc;
        buf_mis  <= (pc[1:0] != 2'b00);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: stream model plus directed scenarios.
`default_nettype none

module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam InstAddr RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int mem_lat  = 0;
  int mem_cnt  = 0;

  InstAddr d_pc[$];
  Inst     d_inst[$];
  logic    d_mis[$];
  int      d_cyc[$];

  function automatic Inst word_at(input InstAddr a);
    return a * 32'd3 + 32'h1357_0000;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Memory: acks once the read has been presented for mem_lat extra cycles.
  always @(negedge clk) begin
    if (rst_n && bus.mem_read) begin
      bus.mem_ready = (mem_cnt >= mem_lat);
      bus.mem_data  = bus.mem_ready ? word_at(bus.mem_addr) : 32'hDEAD_BEEF;
      mem_cnt       = bus.mem_ready ? 0 : mem_cnt + 1;
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_data  = 32'hDEAD_BEEF;
      mem_cnt       = 0;
    end
  end

  // Stream model: decode must see consecutive words from the last redirect target.
  InstAddr m_next    = RESET_PC;
  logic    flushed   = 1'b0;
  logic    prev_read = 1'b0;
  logic    prev_ack  = 1'b0;
  InstAddr prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      cycle++;
      if (!rst_n) begin
        m_next    = RESET_PC;
        flushed   = 1'b0;
        prev_read = 1'b0;
        prev_ack  = 1'b0;
      end else begin
        if (flushed) check_eq("valid_after_redirect", bus.valid, 1'b0);
        check_eq("read_with_full_buffer", bus.mem_read && bus.valid, 1'b0);
        if (prev_read && !prev_ack) begin
          check_eq("mem_read_held", bus.mem_read, 1'b1);
          check_eq("mem_addr_held", bus.mem_addr, prev_addr);
        end
        if (bus.valid) begin
          check_eq("stream_pc", bus.pc, m_next);
          check_eq("stream_inst", bus.inst, word_at(m_next));
          check_eq("stream_misaligned", bus.misaligned, m_next[1:0] != 2'b00);
        end
        if (bus.valid && bus.ready) begin
          d_pc.push_back(bus.pc);
          d_inst.push_back(bus.inst);
          d_mis.push_back(bus.misaligned);
          d_cyc.push_back(cycle);
          m_next = m_next + 32'd4;
        end
        flushed = bus.redirect;
        if (bus.redirect) m_next = bus.redirect_pc;
        prev_read = bus.mem_read;
        prev_ack  = bus.mem_read && bus.mem_ready;
        prev_addr = bus.mem_addr;
      end
    end
  end

  task automatic wait_deliv(input int target, input string name, output logic ok);
    int n = 0;
    while (d_pc.size() < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = (d_pc.size() >= target);
    check_eq(name, ok, 1'b1);
  endtask

  task automatic wait_req_start(input string name);
    logic was = 1'b1;
    logic hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (bus.mem_read && !was) hit = 1'b1;
      was = bus.mem_read;
    end
    check_eq(name, hit, 1'b1);
  endtask

  task automatic redirect_to(input InstAddr target, output int base);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    @(negedge clk);
    bus.redirect = 1'b0;
    base = d_pc.size();
  endtask

  initial begin
    int      base;
    int      held_n;
    logic    ok;
    logic    seen;
    InstAddr held;
    InstAddr old;

    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.ready       = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check_eq("reset_valid", bus.valid, 1'b0);
    check_eq("reset_mem_read", bus.mem_read, 1'b0);
    check_eq("reset_pc", bus.pc, 32'h0);
    check_eq("reset_inst", bus.inst, 32'h0);
    check_eq("reset_misaligned", bus.misaligned, 1'b0);
    check_eq("reset_mem_addr", bus.mem_addr, RESET_PC);

    // 1: sequential fetch, zero-wait memory
    @(negedge clk);
    rst_n = 1'b1;
    wait_deliv(3, "t1_deliveries", ok);
    if (ok) begin
      check_eq("t1_pc0", d_pc[0], 32'h0);
      check_eq("t1_pc1", d_pc[1], 32'h4);
      check_eq("t1_pc2", d_pc[2], 32'h8);
      check_eq("t1_inst0", d_inst[0], 32'h1357_0000);
      check_eq("t1_inst1", d_inst[1], 32'h1357_000C);
      check_eq("t1_inst2", d_inst[2], 32'h1357_0018);
      check_eq("t1_period_a", d_cyc[1] - d_cyc[0], 2);
      check_eq("t1_period_b", d_cyc[2] - d_cyc[1], 2);
    end

    // 2: decode stalls with a full buffer
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.valid;
    end
    check_eq("t2_valid_found", seen, 1'b1);
    held      = bus.pc;
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      check_eq("t2_stall_no_read", bus.mem_read, 1'b0);
      check_eq("t2_stall_valid", bus.valid, 1'b1);
      check_eq("t2_stall_pc", bus.pc, held);
      @(negedge clk);
    end
    bus.ready = 1'b1;
    base = d_pc.size();
    wait_deliv(base + 2, "t2_resume", ok);
    if (ok) begin
      check_eq("t2_held_delivered", d_pc[base], held);
      check_eq("t2_next_addr", d_pc[base + 1], held + 32'd4);
    end

    // 3: redirect during a slow read
    #1 mem_lat = 3;
    wait_req_start("t3_req_seen");
    old = bus.mem_addr;
    redirect_to(32'h100, base);
    held_n = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (!bus.mem_read) break;
      held_n++;
      check_eq("t3_drop_addr_hold", bus.mem_addr, old);
      if (bus.mem_ready) break;
      @(negedge clk);
    end
    check_eq("t3_drop_cycles", held_n, 3);
    wait_req_start("t3_refetch_seen");
    check_eq("t3_refetch_addr", bus.mem_addr, 32'h100);
    wait_deliv(base + 1, "t3_delivery", ok);
    if (ok) begin
      check_eq("t3_pc", d_pc[base], 32'h100);
      check_eq("t3_inst", d_inst[base], 32'h1357_0300);
    end

    // 4: redirect on the same cycle as the memory ack
    #1 mem_lat = 0;
    wait_req_start("t4_req_seen");
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    #3;
    check_eq("t4_ack_with_redirect", bus.mem_ready, 1'b1);
    @(negedge clk);
    bus.redirect = 1'b0;
    base = d_pc.size();
    #3;
    check_eq("t4_valid_cleared", bus.valid, 1'b0);
    wait_deliv(base + 1, "t4_delivery", ok);
    if (ok) begin
      check_eq("t4_pc", d_pc[base], 32'h200);
      check_eq("t4_inst", d_inst[base], 32'h1357_0600);
    end

    // 5: misaligned target, then PC wrap-around
    @(negedge clk);
    redirect_to(32'h102, base);
    wait_deliv(base + 2, "t5_mis_delivery", ok);
    if (ok) begin
      check_eq("t5_pc_a", d_pc[base], 32'h102);
      check_eq("t5_inst_a", d_inst[base], 32'h1357_0306);
      check_eq("t5_mis_a", d_mis[base], 1'b1);
      check_eq("t5_pc_b", d_pc[base + 1], 32'h106);
      check_eq("t5_mis_b", d_mis[base + 1], 1'b1);
    end
    @(negedge clk);
    redirect_to(32'hFFFF_FFFC, base);
    wait_deliv(base + 2, "t5_wrap_delivery", ok);
    if (ok) begin
      check_eq("t5_pc_top", d_pc[base], 32'hFFFF_FFFC);
      check_eq("t5_inst_top", d_inst[base], 32'h1356_FFF4);
      check_eq("t5_mis_top", d_mis[base], 1'b0);
      check_eq("t5_pc_wrap", d_pc[base + 1], 32'h0);
      check_eq("t5_inst_wrap", d_inst[base + 1], 32'h1357_0000);
    end

    // 6: asynchronous reset in the middle of a read
    #1 mem_lat = 3;
    wait_req_start("t6_req_seen");
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_read_drops_async", bus.mem_read, 1'b0);
    check_eq("t6_valid_reset", bus.valid, 1'b0);
    repeat (2) @(negedge clk);
    mem_lat = 0;
    rst_n   = 1'b1;
    base    = d_pc.size();
    wait_deliv(base + 1, "t6_delivery", ok);
    if (ok) begin
      check_eq("t6_pc_restart", d_pc[base], RESET_PC);
      check_eq("t6_inst_restart", d_inst[base], 32'h1357_0000);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
